// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard that raises stall for RAW, WAW and
// busy mul/div hazards and reports when the ID instruction issues.
module hazard_scoreboard #(
  parameter int LOAD_LAT   = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       id_valid,
  input  logic [4:0] id_rs_index,
  input  logic [4:0] id_rt_index,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [4:0] id_dst_index,
  input  logic       id_regwrite_en,
  input  logic       id_is_load,
  input  logic       id_is_muldiv,
  output logic       stall,
  output logic       issue,
  output logic       muldiv_busy
);

  logic [2:0] cnt_q [1:31];
  logic [2:0] cnt_d [1:31];
  logic [2:0] cnt_v [32];
  logic [2:0] md_q, md_d;
  logic [2:0] new_lat;
  logic       rs_blk, rt_blk, waw_blk, str_blk;

  // r0 reads as an always-ready entry so index 0 needs no special path
  always_comb begin
    cnt_v[0] = '0;
    for (int r = 1; r < 32; r++) cnt_v[r] = cnt_q[r];
  end

  always_comb begin
    new_lat = '0;
    if (id_is_muldiv)    new_lat = 3'(MULDIV_LAT);
    else if (id_is_load) new_lat = 3'(LOAD_LAT);
  end

  assign rs_blk = id_valid & id_rs_used & (id_rs_index != '0)
                & (cnt_v[id_rs_index] != '0);
  assign rt_blk = id_valid & id_rt_used & (id_rt_index != '0)
                & (cnt_v[id_rt_index] != '0);
  assign waw_blk = id_valid & id_regwrite_en & (id_dst_index != '0)
                 & (cnt_v[id_dst_index] > new_lat);
  assign str_blk = id_valid & id_is_muldiv & (md_q != '0);

  assign stall = ~flush & (rs_blk | rt_blk | waw_blk | str_blk);
  assign issue = id_valid & ~stall & ~flush;
  assign muldiv_busy = (md_q != '0);

  always_comb begin
    for (int r = 1; r < 32; r++) begin
      cnt_d[r] = '0;
      if (!flush) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 3'd1;
        if (issue && id_regwrite_en && id_dst_index == 5'(r))
          cnt_d[r] = new_lat;
      end
    end
  end

  always_comb begin
    md_d = '0;
    if (!flush) begin
      if (issue && id_is_muldiv) md_d = 3'(MULDIV_LAT);
      else if (md_q != '0)       md_d = md_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= '0;
      md_q <= '0;
    end else begin
      for (int r = 1; r < 32; r++) cnt_q[r] <= cnt_d[r];
      md_q <= md_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with default latencies
// (LOAD_LAT=1, MULDIV_LAT=4).
module tb_hazard_scoreboard;

  logic       clk, rst, flush, id_valid;
  logic [4:0] id_rs_index, id_rt_index, id_dst_index;
  logic       id_rs_used, id_rt_used, id_regwrite_en;
  logic       id_is_load, id_is_muldiv;
  logic       stall, issue, muldiv_busy;

  int ntests = 0;
  int nfails = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_rs_index(id_rs_index), .id_rt_index(id_rt_index),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_dst_index(id_dst_index), .id_regwrite_en(id_regwrite_en),
    .id_is_load(id_is_load), .id_is_muldiv(id_is_muldiv),
    .stall(stall), .issue(issue), .muldiv_busy(muldiv_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    ntests++;
    assert (obs === exp) else begin
      nfails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v,
                       input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu,
                       input logic [4:0] dst, input logic we,
                       input logic ld, input logic md);
    id_valid = v;
    id_rs_index = rs; id_rs_used = rsu;
    id_rt_index = rt; id_rt_used = rtu;
    id_dst_index = dst; id_regwrite_en = we;
    id_is_load = ld; id_is_muldiv = md;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    idle();
    #2;
    // reset state: issue follows id_valid
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_issue", issue, 1'b1);
    chk("rst_busy", muldiv_busy, 1'b0);
    tick();
    chk("rst_edge_stall", stall, 1'b0);
    chk("rst_edge_busy", muldiv_busy, 1'b0);
    rst = 1'b1;
    tick();

    // load r5 then dependent add
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    chk("ld_issue", issue, 1'b1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    chk("ld_use_stall", stall, 1'b1);
    chk("ld_use_noissue", issue, 1'b0);
    tick();
    #1;
    chk("ld_use_stall2", stall, 1'b0);
    chk("ld_use_issue2", issue, 1'b1);
    tick();

    // ALU write then consumers never stall
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    #1;
    chk("alu_issue", issue, 1'b1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("alu_fwd_stall", stall, 1'b0);
      chk("alu_fwd_issue", issue, 1'b1);
      tick();
    end

    // mul r8 then independent mul: structural stall
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
    #1;
    chk("mul1_issue", issue, 1'b1);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mul2_stall", stall, 1'b1);
      chk("mul2_busy", muldiv_busy, 1'b1);
      tick();
    end
    #1;
    chk("mul2_go_stall", stall, 1'b0);
    chk("mul2_go_issue", issue, 1'b1);
    chk("mul2_go_busy", muldiv_busy, 1'b0);
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("mul2_busy_win", muldiv_busy, 1'b1);
      tick();
    end
    #1;
    chk("mul2_busy_end", muldiv_busy, 1'b0);
    tick();

    // mul r8 then ALU reading+writing r8: RAW and WAW stall once
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1);
    #1;
    chk("waw_mul_issue", issue, 1'b1);
    tick();
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("waw_stall", stall, 1'b1);
      tick();
    end
    #1;
    chk("waw_go_stall", stall, 1'b0);
    chk("waw_go_issue", issue, 1'b1);
    tick();
    drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    #1;
    chk("waw_after_stall", stall, 1'b0);
    tick();

    // WAW boundary: equal latency does not stall, greater does
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
    #1;
    chk("bnd_ld1_issue", issue, 1'b1);
    tick();
    #1;
    chk("bnd_ld2_stall", stall, 1'b0);
    chk("bnd_ld2_issue", issue, 1'b1);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    #1;
    chk("bnd_alu_stall", stall, 1'b1);
    tick();
    #1;
    chk("bnd_alu_issue", issue, 1'b1);
    tick();

    // flush squashes in-flight mul r3
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
    #1;
    chk("fl_mul_issue", issue, 1'b1);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    chk("fl_stall", stall, 1'b0);
    chk("fl_issue", issue, 1'b0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_after_stall", stall, 1'b0);
    chk("fl_after_issue", issue, 1'b1);
    chk("fl_after_busy", muldiv_busy, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    #1;
    chk("r0_mul_issue", issue, 1'b1);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("r0_use_stall", stall, 1'b0);
    chk("r0_use_issue", issue, 1'b1);
    tick();
    idle();
    repeat (4) tick();

    // async reset mid-countdown with cnt[9]=3
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b1);
    #1;
    chk("ar_mul_issue", issue, 1'b1);
    tick();
    idle();
    tick();
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("ar_pre_stall", stall, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_in_stall", stall, 1'b0);
    chk("ar_in_issue", issue, 1'b1);
    chk("ar_in_busy", muldiv_busy, 1'b0);
    rst = 1'b1;
    #1;
    chk("ar_rel_stall", stall, 1'b0);
    tick();
    #1;
    chk("ar_post_stall", stall, 1'b0);
    chk("ar_post_issue", issue, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", ntests, nfails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter LOAD_LAT, default 1, meaning: cycles after issue until a load result is forwardable from MEM; legal range 1..7.
REQ-002 Parameter MULDIV_LAT, default 4, meaning: cycles after issue until a mul/div result is forwardable; legal range 1..7.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 flush  input  1  squash all in-flight producers (exception/branch redirect).
REQ-006 id_valid  input  1  an instruction is present in ID.
REQ-007 id_rs_index, id_rt_index  input  5 each  source register indices.
REQ-008 id_rs_used, id_rt_used  input  1 each  source is actually read.
REQ-009 id_dst_index  input  5  destination register index.
REQ-010 id_regwrite_en  input  1  instruction writes id_dst_index.
REQ-011 id_is_load, id_is_muldiv  input  1 each  producer class; both 1 is illegal and treated as muldiv.
REQ-012 stall  output  1  hold PC and IF/ID; insert bubble into EX.
REQ-013 issue  output  1  instruction in ID advances to EX this cycle.
REQ-014 muldiv_busy  output  1  a mul/div is in flight.

Function
REQ-015 The block SHALL hold one 3-bit countdown cnt[r] per register r=1..31; cnt[r]=N means r's value is not forwardable for N more cycles; register 0 has no entry and never causes a stall.
REQ-016 A source is blocked when id_valid, its _used bit is 1, its index != 0 and cnt[index] != 0.
REQ-017 new_lat = MULDIV_LAT if id_is_muldiv, else LOAD_LAT if id_is_load, else 0 (ALU results are forwardable from EX the next cycle).
REQ-018 WAW block: id_valid, id_regwrite_en, id_dst_index != 0 and cnt[id_dst_index] > new_lat.
REQ-019 Structural block: id_valid, id_is_muldiv and muldiv counter != 0.
REQ-020 stall SHALL be combinational: 1 iff flush=0 and any of REQ-016/018/019 holds.
REQ-021 issue SHALL be combinational: id_valid & ~stall & ~flush.
REQ-022 Every rising edge with flush=0: each nonzero cnt[r] decrements by 1, saturating at 0.
REQ-023 On issue with id_regwrite_en=1 and id_dst_index != 0, cnt[id_dst_index] SHALL load new_lat at that edge, overriding its decrement.
REQ-024 On issue with id_is_muldiv=1 the muldiv counter SHALL load MULDIV_LAT; otherwise it decrements to 0; muldiv_busy = (muldiv counter != 0), registered.
REQ-025 flush=1 at an edge SHALL clear all cnt[] and the muldiv counter; stall=0 and issue=0 during that cycle.
REQ-026 Stall-to-issue latency SHALL be exactly cnt[src] cycles: a consumer issues in the first cycle its counter reads 0.
REQ-027 Simultaneous RAW and WAW on the same register SHALL stall once, with no double counting.

Reset
REQ-028 While rst=0, independent of clk, all cnt[] and the muldiv counter SHALL be 0; stall=0, muldiv_busy=0, and issue follows id_valid.
REQ-029 Reset asserted mid-countdown SHALL discard all pending state; the first edge after release behaves as an empty scoreboard.

Verification
REQ-030 Load to r5 issued at t0 (LOAD_LAT=1), dependent add reading r5 in ID at t1 -> stall=1 at t1, issue=1 at t2.
REQ-031 ALU write to r5 followed by a consumer of r5 -> stall never asserts and issue=1 every cycle.
REQ-032 mul to r8 (MULDIV_LAT=4), then second mul with no register overlap -> stalled 4 cycles by muldiv_busy; muldiv_busy=1 for exactly 4 cycles.
REQ-033 mul to r8, then ALU write to r8 -> WAW stall until cnt[8]=0; afterwards cnt[8]=0.
REQ-034 Load to r3, flush=1 at the next edge, consumer of r3 -> no stall after flush; consumer of r0 -> never stalls.
REQ-035 rst driven low between edges with cnt[9]=3 -> stall drops immediately; after release, reading r9 issues with zero stall.
